// File: rtl/run_length_detector.sv
// Purpose : flags when the serial input w has held one value for RUN_LEN or more enabled samples.
// Latency : z/hit are registered-state outputs, visible one edge after the RUN_LEN-th enabled sample.
// Backpressure: none; en=0 freezes the run (hit pulse still drops), sclr restarts it.
//
// Ports:
//   clk      rising-edge clock
//   aclr     asynchronous clear, active-high (whole block, including ev_cnt)
//   sclr     synchronous run clear (state IDLE, run_cnt 0, hit 0; ev_cnt kept)
//   en       sample enable for w
//   w        serial data input
//   mode     00 both values, 01 ones only, 10 zeros only, 11 none
//   clr_ev   synchronous clear of ev_cnt (wins over increment)
//   z        level: current run >= RUN_LEN and its value is allowed by mode
//   z_val    value of the current run (meaningful when state_o != IDLE)
//   hit      one-cycle pulse when the run first reaches RUN_LEN (mode-gated)
//   run_cnt  current run length, saturating at RUN_LEN
//   ev_cnt   number of counted hits, saturating at all-ones
//   state_o  00 IDLE, 01 RUN0, 10 RUN1
module run_length_detector #(
    parameter  int RUN_LEN = 4,
    parameter  int EV_W    = 8,
    localparam int CW      = $clog2(RUN_LEN + 1)
) (
    input  logic            clk,
    input  logic            aclr,
    input  logic            sclr,
    input  logic            en,
    input  logic            w,
    input  logic [1:0]      mode,
    input  logic            clr_ev,
    output logic            z,
    output logic            z_val,
    output logic            hit,
    output logic [CW-1:0]   run_cnt,
    output logic [EV_W-1:0] ev_cnt,
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN0 = 2'b01,
        RUN1 = 2'b10
    } state_t;

    localparam logic [CW-1:0]   RUN_MAX = CW'(RUN_LEN);
    localparam logic [CW-1:0]   RUN_PRE = CW'(RUN_LEN - 1);
    localparam logic [EV_W-1:0] EV_MAX  = {EV_W{1'b1}};

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            zval_q,  zval_d;
    logic            hit_q,   hit_d;
    logic [EV_W-1:0] ev_q,    ev_d;

    // Mode mask: which run values are allowed to raise z / hit / count.
    function automatic logic allow(input logic [1:0] m, input logic v);
        return (m == 2'b00) | ((m == 2'b01) & v) | ((m == 2'b10) & ~v);
    endfunction

    // Next-state logic. sclr outranks en; hit_d only fires on the exact
    // RUN_LEN-1 -> RUN_LEN step, so a saturated run never re-hits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        zval_d  = zval_q;
        hit_d   = 1'b0;
        if (sclr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (en) begin
            if (state_q == (w ? RUN1 : RUN0)) begin
                if (cnt_q != RUN_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (cnt_q == RUN_PRE) begin
                    hit_d = 1'b1;
                end
            end else begin
                // From IDLE or a run of the other value: start a fresh run.
                state_d = w ? RUN1 : RUN0;
                cnt_d   = CW'(1);
                zval_d  = w;
            end
        end
    end

    // Event counter. On a hitting edge w equals the run value, so the mask
    // is applied to w as sampled at that edge.
    always_comb begin
        ev_d = ev_q;
        if (clr_ev) begin
            ev_d = '0;
        end else if (hit_d && allow(mode, w) && (ev_q != EV_MAX)) begin
            ev_d = ev_q + EV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            zval_q  <= 1'b0;
            hit_q   <= 1'b0;
            ev_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zval_q  <= zval_d;
            hit_q   <= hit_d;
            ev_q    <= ev_d;
        end
    end

    // Outputs depend only on registered state plus the quasi-static mode,
    // so a mode change is reflected immediately without a w path.
    assign z       = (cnt_q == RUN_MAX) & allow(mode, zval_q);
    assign hit     = hit_q & allow(mode, zval_q);
    assign z_val   = zval_q;
    assign run_cnt = cnt_q;
    assign ev_cnt  = ev_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_run_length_detector.sv
// Bench for run_length_detector: two instances (RUN_LEN 4/EV_W 8 and RUN_LEN 7/EV_W 2)
// share one stimulus stream; a run-length model is compared every cycle, plus literal
// expectations for the directed scenarios.
module tb_run_length_detector;

    logic       clk = 1'b0;
    logic       aclr, sclr, en, w, clr_ev;
    logic [1:0] mode;

    logic       za, zva, ha;
    logic [2:0] rca;
    logic [7:0] eva;
    logic [1:0] sta;

    logic       zb, zvb, hb;
    logic [2:0] rcb;
    logic [1:0] evb;
    logic [1:0] stb;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    run_length_detector #(.RUN_LEN(4), .EV_W(8)) dut_a (
        .clk(clk), .aclr(aclr), .sclr(sclr), .en(en), .w(w), .mode(mode), .clr_ev(clr_ev),
        .z(za), .z_val(zva), .hit(ha), .run_cnt(rca), .ev_cnt(eva), .state_o(sta)
    );

    run_length_detector #(.RUN_LEN(7), .EV_W(2)) dut_b (
        .clk(clk), .aclr(aclr), .sclr(sclr), .en(en), .w(w), .mode(mode), .clr_ev(clr_ev),
        .z(zb), .z_val(zvb), .hit(hb), .run_cnt(rcb), .ev_cnt(evb), .state_o(stb)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Tracks the true (unbounded) length of the current run; everything else
    // is derived from it.
    bit m_idle [2] = '{1'b1, 1'b1};
    bit m_val  [2] = '{1'b0, 1'b0};
    int m_len  [2] = '{0, 0};
    bit m_hitr [2] = '{1'b0, 1'b0};
    int m_ev   [2] = '{0, 0};

    function automatic int rl(input int i);
        return (i == 0) ? 4 : 7;
    endfunction

    function automatic int evmax(input int i);
        return (i == 0) ? 255 : 3;
    endfunction

    function automatic bit allowed(input logic [1:0] m, input bit v);
        case (m)
            2'b00:   return 1'b1;
            2'b01:   return v;
            2'b10:   return !v;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int mz(input int i);
        return (!m_idle[i] && m_len[i] >= rl(i) && allowed(mode, m_val[i])) ? 1 : 0;
    endfunction

    function automatic int mhit(input int i);
        return (m_hitr[i] && allowed(mode, m_val[i])) ? 1 : 0;
    endfunction

    function automatic int mrc(input int i);
        return (m_len[i] < rl(i)) ? m_len[i] : rl(i);
    endfunction

    function automatic int mst(input int i);
        return m_idle[i] ? 0 : (m_val[i] ? 2 : 1);
    endfunction

    always @(posedge clk or posedge aclr) begin
        for (int i = 0; i < 2; i++) begin
            if (aclr) begin
                m_idle[i] = 1'b1;
                m_val[i]  = 1'b0;
                m_len[i]  = 0;
                m_hitr[i] = 1'b0;
                m_ev[i]   = 0;
            end else begin
                bit hn;
                hn = 1'b0;
                if (sclr) begin
                    m_idle[i] = 1'b1;
                    m_len[i]  = 0;
                end else if (en) begin
                    if (!m_idle[i] && w == m_val[i]) begin
                        m_len[i] = m_len[i] + 1;
                    end else begin
                        m_idle[i] = 1'b0;
                        m_val[i]  = w;
                        m_len[i]  = 1;
                    end
                    hn = (m_len[i] == rl(i));
                end
                if (clr_ev) m_ev[i] = 0;
                else if (hn && allowed(mode, w) && m_ev[i] < evmax(i)) m_ev[i] = m_ev[i] + 1;
                m_hitr[i] = hn;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cmp(input int i, input int z_a, input int h_a, input int zv_a,
                       input int rc_a, input int ev_a, input int st_a);
        check($sformatf("z[%0d]", i), z_a, mz(i));
        check($sformatf("hit[%0d]", i), h_a, mhit(i));
        check($sformatf("run_cnt[%0d]", i), rc_a, mrc(i));
        check($sformatf("ev_cnt[%0d]", i), ev_a, m_ev[i]);
        check($sformatf("state[%0d]", i), st_a, mst(i));
        if (!m_idle[i]) check($sformatf("z_val[%0d]", i), zv_a, int'(m_val[i]));
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp(0, int'(za), int'(ha), int'(zva), int'(rca), int'(eva), int'(sta));
            cmp(1, int'(zb), int'(hb), int'(zvb), int'(rcb), int'(evb), int'(stb));
        end
    end

    // Inputs change 1 time unit after the rising edge.
    task automatic tick(input bit e, input bit wv);
        en = e;
        w  = wv;
        @(posedge clk);
        #1;
    endtask

    int exp_ev [4] = '{1, 2, 3, 3};
    int hit_cnt;

    initial begin
        aclr = 1'b0; sclr = 1'b0; en = 1'b0; w = 1'b0; mode = 2'b00; clr_ev = 1'b0;
        #1 aclr = 1'b1;
        #1;
        check("rst_z", int'(za), 0);
        check("rst_hit", int'(ha), 0);
        check("rst_run_cnt", int'(rca), 0);
        check("rst_ev_cnt", int'(eva), 0);
        check("rst_state", int'(sta), 0);
        check("rst_z_val", int'(zva), 0);
        @(posedge clk);
        #1 aclr = 1'b0;
        chk_on = 1'b1;

        // 1: four zeros hit, six more hold z without re-hit
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b0);
        check("t1_z", int'(za), 1);
        check("t1_hit", int'(ha), 1);
        check("t1_z_val", int'(zva), 0);
        check("t1_run_cnt", int'(rca), 4);
        check("t1_ev_cnt", int'(eva), 1);
        check("t1_model_rc", mrc(0), 4);
        check("t1_b_z", int'(zb), 0);
        for (int k = 0; k < 6; k++) begin
            tick(1'b1, 1'b0);
            check("t1_hold_z", int'(za), 1);
            check("t1_hold_hit", int'(ha), 0);
        end
        check("t1_ev_hold", int'(eva), 1);
        check("t1_model_ev", m_ev[0], 1);

        // 2: 1,1,1,0 never raises z
        tick(1'b1, 1'b1); check("t2_z0", int'(za), 0);
        tick(1'b1, 1'b1); check("t2_z1", int'(za), 0);
        tick(1'b1, 1'b1); check("t2_z2", int'(za), 0);
        tick(1'b1, 1'b0); check("t2_z3", int'(za), 0);
        check("t2_state", int'(sta), 1);
        check("t2_run_cnt", int'(rca), 1);
        check("t2_z_val", int'(zva), 0);

        // 3: ones-only mode masks a zero run; switching to both shows z at once
        mode = 2'b01;
        clr_ev = 1'b1;
        tick(1'b1, 1'b0);
        clr_ev = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b0);
            check("t3_z", int'(za), 0);
            check("t3_hit", int'(ha), 0);
        end
        check("t3_ev", int'(eva), 0);
        check("t3_run_cnt", int'(rca), 4);
        mode = 2'b00;
        #1;
        check("t3_z_mode", int'(za), 1);
        check("t3_hit_mode", int'(ha), 0);
        check("t3_ev_mode", int'(eva), 0);

        // 4: en gaps hold the run
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0);
            check("t4_hold_cnt", int'(rca), 2);
            check("t4_hold_z", int'(za), 0);
        end
        tick(1'b1, 1'b1);
        check("t4_z3", int'(za), 0);
        tick(1'b1, 1'b1);
        check("t4_z4", int'(za), 1);
        check("t4_hit4", int'(ha), 1);
        check("t4_ev4", int'(eva), 1);
        check("t4_state", int'(sta), 2);

        // 5: asynchronous clear between edges, then sclr/clr_ev on the hitting edge
        #1 aclr = 1'b1;
        #1;
        check("t5_aclr_z", int'(za), 0);
        check("t5_aclr_hit", int'(ha), 0);
        check("t5_aclr_cnt", int'(rca), 0);
        check("t5_aclr_ev", int'(eva), 0);
        #1 aclr = 1'b0;
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b1);
        sclr = 1'b1;
        clr_ev = 1'b1;
        tick(1'b1, 1'b1);
        sclr = 1'b0;
        clr_ev = 1'b0;
        check("t5_sclr_hit", int'(ha), 0);
        check("t5_sclr_ev", int'(eva), 0);
        check("t5_sclr_state", int'(sta), 0);
        check("t5_sclr_cnt", int'(rca), 0);

        // 6: RUN_LEN=7 / EV_W=2 instance, four runs of seven ones
        hit_cnt = 0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 7; k++) begin
                tick(1'b1, 1'b1);
                hit_cnt += int'(hb);
            end
            check("t6_hit", int'(hb), 1);
            check("t6_ev", int'(evb), exp_ev[r]);
            check("t6_run_cnt", int'(rcb), 7);
            tick(1'b1, 1'b0);
            hit_cnt += int'(hb);
            check("t6_hit_drop", int'(hb), 0);
        end
        check("t6_hit_count", hit_cnt, 4);
        check("t6_model_ev", m_ev[1], 3);

        // Random phase: sticky w to build long runs, occasional control events.
        for (int n = 0; n < 4000; n++) begin
            en     = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 99) < 15) w = ~w;
            sclr   = ($urandom_range(0, 99) < 3);
            clr_ev = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 2) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                aclr = 1'b1;
                #1 aclr = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
